// File: rtl/seq_mul_param.sv
//------------------------------------------------------------------------------
// Module  : seq_mul_param
// Brief   : Shift-and-add sequential multiplier, signed/unsigned, with
//           valid/ready handshakes. Optional macro SEQ_MUL_EARLY_TERM_EN
//           ends CALC once the remaining multiplier bits are all zero.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_mul_param #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_NEG  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     ma;
    logic [WIDTH-1:0]     mb;
    logic [CNT_W-1:0]     cnt;
    logic                 neg;

    logic                 accept;
    logic                 calc_last;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH-1:0]     mb_shifted;
    logic [2*WIDTH-1:0]   partial;

    // Negating -2^(WIDTH-1) wraps to itself, which read as unsigned is its magnitude.
    assign a_mag      = (is_signed && a[WIDTH-1]) ? (-a) : a;
    assign b_mag      = (is_signed && b[WIDTH-1]) ? (-b) : b;
    assign mb_shifted = mb >> 1;
    assign partial    = {{WIDTH{1'b0}}, ma} << cnt;
    assign accept     = in_valid && (state == S_IDLE);
    assign p          = acc;

`ifdef SEQ_MUL_EARLY_TERM_EN
    assign calc_last = (cnt == CNT_W'(WIDTH - 1)) || (mb_shifted == '0);
`else
    assign calc_last = (cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (calc_last) begin
                    state_nxt = neg ? S_NEG : S_DONE;
                end
            end
            S_NEG: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ma  <= '0;
            mb  <= '0;
            cnt <= '0;
            neg <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ma  <= a_mag;
                        mb  <= b_mag;
                        neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                S_CALC: begin
                    if (mb[0]) begin
                        acc <= acc + partial;
                    end
                    mb  <= mb_shifted;
                    cnt <= cnt + CNT_W'(1);
                end
                S_NEG: begin
                    acc <= -acc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_mul_param.sv
//------------------------------------------------------------------------------
// Module  : tb_seq_mul_param
// Brief   : Randomized self-checking bench for seq_mul_param against an
//           arithmetic product/latency model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_mul_param;

    localparam int W = 16;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [W-1:0]     a         = '0;
    logic [W-1:0]     b         = '0;
    logic             is_signed = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2*W-1:0]   p;
    logic             busy;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [2*W-1:0]   last_p;

    always #5 clk = ~clk;

    seq_mul_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                                  input logic s);
        longint sx, sy, pr;
        sx = s ? longint'($signed(x)) : longint'(x);
        sy = s ? longint'($signed(y)) : longint'(y);
        pr = sx * sy;
        return pr[2*W-1:0];
    endfunction

    // Cycles from accept edge to out_valid rising.
    function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        longint sy;
        int     n;
        bit     ng;
        ng = s && (x[W-1] ^ y[W-1]);
        sy = s ? longint'($signed(y)) : longint'(y);
        if (sy < 0) sy = -sy;
`ifdef SEQ_MUL_EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < W; i++) if (sy[i]) n = i + 1;
`else
        n = W;
`endif
        return n + (ng ? 1 : 0);
    endfunction

    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si,
                          input int hold);
        logic [2*W-1:0] ep;
        int             el;
        int             cyc;
        ep = model_prod(ai, bi, si);
        el = model_lat(ai, bi, si);
        chk("idle_ready", in_ready, 1);
        a = ai; b = bi; is_signed = si; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_accept", busy, 1);
        chk("ready_low_busy", in_ready, 0);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom);
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (cyc >= 100) begin
            chk("timeout_out_valid", 0, 1);
            rst_n = 1'b0; #1; rst_n = 1'b1;
            @(posedge clk); #1;
            return;
        end
        chk("latency", cyc, el);
        chk("product", p, ep);
        last_p = p;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_p", p, ep);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ready_after_handshake", in_ready, 1);
        chk("valid_after_handshake", out_valid, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [W-1:0] corners [5];
        corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'hFFFF;
        corners[3] = 16'h8000; corners[4] = 16'h7FFF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_p", p, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h7FFF, 16'h7FFF, 1'b1, 20);
        chk("spec_7fff_sq", last_p, 32'h3FFF0001);
        run_op(16'h8000, 16'h8000, 1'b1, 0);
        chk("spec_8000_sq", last_p, 32'h40000000);
        run_op(16'hFFFF, 16'h0001, 1'b1, 2);
        chk("spec_m1_x_1", last_p, 32'hFFFFFFFF);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1);
        chk("spec_ffff_sq_u", last_p, 32'hFFFE0001);
        run_op(16'h8000, 16'h0002, 1'b0, 0);
        chk("spec_8000_x_2_u", last_p, 32'h00010000);
        run_op(16'h1234, 16'h0003, 1'b0, 0);
        run_op(16'h1234, 16'h0000, 1'b0, 0);
        run_op(16'h1234, 16'hFFFF, 1'b1, 0);
        run_op(16'h0000, 16'h8000, 1'b1, 0);

        for (int k = 0; k < 40; k++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0: rb = W'($urandom);
                1: rb = corners[$urandom_range(0, 4)];
                default: rb = W'($urandom_range(0, 7));
            endcase
            if ($urandom_range(0, 3) == 0) ra = corners[$urandom_range(0, 4)];
            run_op(ra, rb, 1'($urandom), $urandom_range(0, 3));
        end

        // Reset in the middle of CALC, then a fresh operation.
        a = 16'h00FF; b = 16'hFFFF; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_p", p, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'd3, 16'd5, 1'b0, 0);
        chk("spec_after_reset", last_p, 32'h0000000F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
